bram_arbiter: RTL

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arbiter_if.sv | 33 +++
 rtl/bram_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bram_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : bram_arbiter_if
// Description : Two-requester handshake/response bundle for bram_arbiter.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface bram_arbiter_if #(
    parameter int W = 32,
    parameter int A = 9
);
    logic [1:0]     req_valid;
    logic [1:0]     req_we;
    logic [1:0]     req_lock;
    logic [2*A-1:0] req_addr;
    logic [2*W-1:0] req_wdata;
    logic [1:0]     req_ready;
    logic [1:0]     rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [1:0]     addr_err;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, addr_err
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, addr_err
    );
endinterface

`default_nettype wire

// File: rtl/bram_arbiter.sv
//------------------------------------------------------------------------------
// Module      : bram_arbiter
// Description : Round-robin two-port arbiter for a single BRAM, with locked
//               bursts capped at MAX_BURST beats and out-of-range detection.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bram_arbiter #(
    parameter int W         = 32,
    parameter int L         = 450,
    parameter int MAX_BURST = 16,
    localparam int A        = $clog2(L)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    bram_arbiter_if.slave     bus,
    output logic [A-1:0]      ram_rd_addr,
    input  wire logic [W-1:0] ram_rd_data,
    output logic [A-1:0]      ram_wr_addr,
    output logic [W-1:0]      ram_wr_data,
    output logic              ram_wr_ena
);

    localparam int         BW  = $clog2(MAX_BURST + 1);
    localparam logic [A:0] c_L = (A + 1)'(L);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [BW-1:0] r_beat_cnt;
    logic [BW-1:0] w_beat_nxt;
    logic          r_last_grant;
    logic [A-1:0]  r_addr_hold;
    logic [1:0]    r_rsp_valid;
    logic [1:0]    r_addr_err;
    logic          r_rsp_oor;

    logic [1:0]    w_ready;
    logic          w_sel;
    logic          w_fire;
    logic          w_sel_we;
    logic          w_sel_lock;
    logic [A-1:0]  w_addr;
    logic          w_in_range;
    logic [1:0]    w_rsp_valid;

    // Grant: round-robin in IDLE, exclusive to the lock holder otherwise
    always_comb begin
        w_ready = 2'b00;
        w_sel   = 1'b0;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.req_valid == 2'b11) w_sel = ~r_last_grant;
                    else                        w_sel = bus.req_valid[1];
                    if (bus.req_valid != 2'b00) w_ready = w_sel ? 2'b10 : 2'b01;
                end
                LOCK0: begin
                    w_sel   = 1'b0;
                    w_ready = {1'b0, bus.req_valid[0]};
                end
                LOCK1: begin
                    w_sel   = 1'b1;
                    w_ready = {bus.req_valid[1], 1'b0};
                end
                default: begin
                    w_ready = 2'b00;
                    w_sel   = 1'b0;
                end
            endcase
        end
    end

    assign w_fire     = |w_ready;
    assign w_sel_we   = w_sel ? bus.req_we[1]   : bus.req_we[0];
    assign w_sel_lock = w_sel ? bus.req_lock[1] : bus.req_lock[0];
    assign w_addr     = w_sel ? bus.req_addr[2*A-1:A] : bus.req_addr[A-1:0];
    assign w_in_range = ({1'b0, w_addr} < c_L);

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_fire && w_sel_lock && (MAX_BURST > 1)) begin
                    w_state_nxt = w_sel ? LOCK1 : LOCK0;
                    w_beat_nxt  = BW'(1);
                end
            end
            LOCK0, LOCK1: begin
                // A lock holder that drops valid forfeits the lock
                if (!w_fire) begin
                    w_state_nxt = IDLE;
                    w_beat_nxt  = '0;
                end else if (!w_sel_lock || (r_beat_cnt == BW'(MAX_BURST - 1))) begin
                    w_state_nxt = IDLE;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt  = r_beat_cnt + BW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_beat_cnt   <= '0;
            r_last_grant <= 1'b1;
            r_addr_hold  <= '0;
            r_rsp_valid  <= 2'b00;
            r_addr_err   <= 2'b00;
            r_rsp_oor    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_cnt  <= w_beat_nxt;
            if (w_fire) begin
                r_last_grant <= w_sel;
                r_addr_hold  <= w_addr;
            end
            r_rsp_valid <= (w_fire && !w_sel_we) ? w_ready : 2'b00;
            r_addr_err  <= (w_fire && !w_in_range) ? w_ready : 2'b00;
            r_rsp_oor   <= !w_in_range;
        end
    end

    assign ram_rd_addr = w_fire ? w_addr : r_addr_hold;
    assign ram_wr_addr = w_fire ? w_addr : r_addr_hold;
    assign ram_wr_data = w_sel ? bus.req_wdata[2*W-1:W] : bus.req_wdata[W-1:0];
    assign ram_wr_ena  = w_fire && w_sel_we && w_in_range;

    // Responses still in flight when reset rises are suppressed immediately
    assign w_rsp_valid   = r_rsp_valid & {2{~rst}};
    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.addr_err  = r_addr_err & {2{~rst}};
    assign bus.rsp_data  = ((|w_rsp_valid) && !r_rsp_oor) ? ram_rd_data : '0;

endmodule

`default_nettype wire
